// File: rtl/route_decision_sequencer_pkg.sv
// Shared Q-routing definitions: widths, sentinel values, FSM and mux encodings, memory map.
package routing_pkg;

    localparam int unsigned WORD_WIDTH   = 16;
    localparam logic [15:0] NEXTHOP_NONE = 16'd100;
    localparam logic [15:0] EPSILON_INIT = 16'd8;
    localparam int unsigned TIMEOUT      = 255;

    // Table-memory map shared by the search and policy blocks.
    localparam logic [15:0] ADDR_QTABLE_BASE   = 16'h668;
    localparam logic [15:0] ADDR_NEIGHBOR_BASE = 16'h68C;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FIND   = 3'd1,
        CLR    = 3'd2,
        POLICY = 3'd3,
        DECAY  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_FIND   = 2'd1,
        SEL_POLICY = 2'd2
    } sel_t;

endpackage

// File: rtl/route_decision_sequencer_if.sv
// Handshake and shared-memory signals between the sequencer and its two sub-blocks.
interface route_decision_sequencer_if
    import routing_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = routing_pkg::WORD_WIDTH
);
    logic                  start_findBest;
    logic                  done_findBest;
    logic [WORD_WIDTH-1:0] address_findBest;
    logic                  policy_nreset;
    logic                  start_winnerPolicy;
    logic                  done_winnerPolicy;
    logic [WORD_WIDTH-1:0] nexthop_policy;
    logic [WORD_WIDTH-1:0] address_winnerPolicy;
    logic [WORD_WIDTH-1:0] mem_address;
    logic [1:0]            mux_select;
    logic [WORD_WIDTH-1:0] epsilon;

    modport master (
        output start_findBest, policy_nreset, start_winnerPolicy,
               mem_address, mux_select, epsilon,
        input  done_findBest, address_findBest, done_winnerPolicy,
               nexthop_policy, address_winnerPolicy
    );

    modport slave (
        input  start_findBest, policy_nreset, start_winnerPolicy,
               mem_address, mux_select, epsilon,
        output done_findBest, address_findBest, done_winnerPolicy,
               nexthop_policy, address_winnerPolicy
    );
endinterface

// File: rtl/route_decision_sequencer_handshake_timeout.sv
// Wait-cycle counter shared by the FIND and POLICY handshakes; flags the last allowed cycle.
module handshake_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic nreset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // High during the TIMEOUT-th cycle spent waiting, so leaving on it gives exactly TIMEOUT cycles.
    assign expired = enable && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/route_decision_sequencer.sv
// Sequences one routing decision: best-neighbour search, policy-block clear/start, epsilon decay.
module route_decision_sequencer
    import routing_pkg::*;
#(
    parameter int unsigned           WORD_WIDTH   = routing_pkg::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] EPSILON_INIT = routing_pkg::EPSILON_INIT,
    parameter int unsigned           TIMEOUT      = routing_pkg::TIMEOUT,
    parameter logic [WORD_WIDTH-1:0] NEXTHOP_NONE = routing_pkg::NEXTHOP_NONE
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start_route,
    output logic                  route_done,
    output logic [WORD_WIDTH-1:0] route_nexthop,
    output logic                  route_error,
    input  logic [WORD_WIDTH-1:0] epsilon_step,
    input  logic                  epsilon_load,
    input  logic [WORD_WIDTH-1:0] epsilon_load_value,
    output logic [2:0]            cstate,
    route_decision_sequencer_if.master bus
);
    state_t                state;
    state_t                next_state;
    sel_t                  mux_q;
    sel_t                  next_mux;
    logic                  start_find_q;
    logic                  start_policy_q;
    logic                  policy_nreset_q;
    logic [WORD_WIDTH-1:0] epsilon_q;
    logic                  timeout_clear;
    logic                  timeout_enable;
    logic                  timeout_expired;

    handshake_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .nreset  (nreset),
        .clear   (timeout_clear),
        .enable  (timeout_enable),
        .expired (timeout_expired)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_route) next_state = FIND;
            FIND: begin
                if (bus.done_findBest)      next_state = CLR;
                else if (timeout_expired)   next_state = ERR;
            end
            CLR:     next_state = POLICY;
            POLICY: begin
                if (bus.done_winnerPolicy)  next_state = DECAY;
                else if (timeout_expired)   next_state = ERR;
            end
            DECAY:   next_state = DONE;
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        next_mux       = SEL_NONE;
        timeout_enable = (state == FIND) || (state == POLICY);
        timeout_clear  = ((next_state == FIND) && (state != FIND)) ||
                         ((next_state == POLICY) && (state != POLICY));
        if (next_state == FIND)   next_mux = SEL_FIND;
        if (next_state == POLICY) next_mux = SEL_POLICY;
    end

    always_ff @(posedge clock) begin
        if (!nreset) state <= IDLE;
        else         state <= next_state;
    end

    // Outputs register the decode of next_state, so each lands on the same edge as the state change.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            start_find_q    <= 1'b0;
            start_policy_q  <= 1'b0;
            policy_nreset_q <= 1'b0;
            mux_q           <= SEL_NONE;
            route_done      <= 1'b0;
            route_error     <= 1'b0;
            route_nexthop   <= NEXTHOP_NONE;
            epsilon_q       <= EPSILON_INIT;
        end else begin
            start_find_q    <= (next_state == FIND);
            start_policy_q  <= (next_state == POLICY);
            policy_nreset_q <= (next_state != CLR);
            mux_q           <= next_mux;
            route_done      <= (next_state == DONE) || (next_state == ERR);
            route_error     <= (next_state == ERR);
            if (next_state == ERR) begin
                route_nexthop <= NEXTHOP_NONE;
            end else if ((state == POLICY) && bus.done_winnerPolicy) begin
                route_nexthop <= bus.nexthop_policy;
            end
            if ((state == IDLE) && epsilon_load && !start_route) begin
                epsilon_q <= epsilon_load_value;
            end else if (state == DECAY) begin
                epsilon_q <= (epsilon_q < epsilon_step) ? '0 : epsilon_q - epsilon_step;
            end
        end
    end

    always_comb begin
        bus.mem_address = '0;
        unique case (mux_q)
            SEL_FIND:   bus.mem_address = bus.address_findBest;
            SEL_POLICY: bus.mem_address = bus.address_winnerPolicy;
            default:    bus.mem_address = '0;
        endcase
    end

    assign bus.start_findBest     = start_find_q;
    assign bus.start_winnerPolicy = start_policy_q;
    assign bus.policy_nreset      = policy_nreset_q;
    assign bus.mux_select         = mux_q;
    assign bus.epsilon            = epsilon_q;
    assign cstate                 = state;
endmodule

// File: tb/tb_route_decision_sequencer.sv
// Directed bench for route_decision_sequencer; sub-block handshakes are driven by hand on negedges.
module tb_route_decision_sequencer;
    import routing_pkg::*;

    logic        clock = 1'b0;
    logic        nreset;
    logic        start_route;
    logic        route_done;
    logic [15:0] route_nexthop;
    logic        route_error;
    logic [15:0] epsilon_step;
    logic        epsilon_load;
    logic [15:0] epsilon_load_value;
    logic [2:0]  cstate;

    int n_cmp = 0;
    int n_bad = 0;
    int done_pulses = 0;

    route_decision_sequencer_if #(.WORD_WIDTH(16)) bus ();

    route_decision_sequencer #(
        .WORD_WIDTH   (16),
        .EPSILON_INIT (16'd8),
        .TIMEOUT      (255),
        .NEXTHOP_NONE (16'd100)
    ) dut (
        .clock              (clock),
        .nreset             (nreset),
        .start_route        (start_route),
        .route_done         (route_done),
        .route_nexthop      (route_nexthop),
        .route_error        (route_error),
        .epsilon_step       (epsilon_step),
        .epsilon_load       (epsilon_load),
        .epsilon_load_value (epsilon_load_value),
        .cstate             (cstate),
        .bus                (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (route_done === 1'b1) done_pulses++;

    // Policy handshake from CLR onwards: model the block reset, then return nh after pol_delay cycles.
    task automatic finish_policy(input int pol_delay, input logic [15:0] nh, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && bus.policy_nreset !== 1'b0; i++) @(negedge clock);
        bus.done_winnerPolicy = 1'b0;
        for (int i = 0; i < 10 && bus.start_winnerPolicy !== 1'b1; i++) @(negedge clock);
        repeat (pol_delay) @(negedge clock);
        bus.nexthop_policy    = nh;
        bus.done_winnerPolicy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (route_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
    endtask

    task automatic run_decision(input int find_delay, input int pol_delay, input logic [15:0] nh,
                                output bit ok);
        start_route = 1'b1;
        @(negedge clock);
        start_route = 1'b0;
        repeat (find_delay - 1) @(negedge clock);
        bus.done_findBest = 1'b1;
        @(negedge clock);
        bus.done_findBest = 1'b0;
        finish_policy(pol_delay, nh, ok);
    endtask

    task automatic test_reset();
        nreset = 1'b0; start_route = 1'b0; epsilon_load = 1'b0;
        epsilon_load_value = '0; epsilon_step = 16'd1;
        bus.done_findBest = 1'b0; bus.done_winnerPolicy = 1'b0; bus.nexthop_policy = '0;
        bus.address_findBest     = ADDR_NEIGHBOR_BASE;
        bus.address_winnerPolicy = ADDR_QTABLE_BASE + 16'd2;
        repeat (3) @(negedge clock);
        n_cmp++; if (route_done !== 1'b0) begin n_bad++; $display("FAIL reset_route_done: got %b want 0", route_done); end
        n_cmp++; if (route_error !== 1'b0) begin n_bad++; $display("FAIL reset_route_error: got %b want 0", route_error); end
        n_cmp++; if (bus.start_findBest !== 1'b0 || bus.start_winnerPolicy !== 1'b0) begin n_bad++; $display("FAIL reset_starts: got %b%b want 00", bus.start_findBest, bus.start_winnerPolicy); end
        n_cmp++; if (bus.mux_select !== 2'd0) begin n_bad++; $display("FAIL reset_mux: got %0d want 0", bus.mux_select); end
        n_cmp++; if (route_nexthop !== 16'd100) begin n_bad++; $display("FAIL reset_nexthop: got %0d want 100", route_nexthop); end
        n_cmp++; if (bus.epsilon !== 16'd8) begin n_bad++; $display("FAIL reset_epsilon: got %0d want 8", bus.epsilon); end
        n_cmp++; if (bus.policy_nreset !== 1'b0) begin n_bad++; $display("FAIL reset_policy_nreset: got %b want 0", bus.policy_nreset); end
        n_cmp++; if (cstate !== 3'd0) begin n_bad++; $display("FAIL reset_cstate: got %0d want 0", cstate); end
        n_cmp++; if (bus.mem_address !== 16'h0) begin n_bad++; $display("FAIL reset_mem_address: got %h want 0000", bus.mem_address); end
        nreset = 1'b1;
        @(negedge clock);
        n_cmp++; if (bus.policy_nreset !== 1'b1) begin n_bad++; $display("FAIL idle_policy_nreset: got %b want 1", bus.policy_nreset); end
    endtask

    task automatic test_normal_decision();
        int p0;
        p0 = done_pulses;
        start_route = 1'b1;
        @(negedge clock);
        start_route = 1'b0;
        n_cmp++; if (cstate !== 3'd1 || bus.start_findBest !== 1'b1) begin n_bad++; $display("FAIL find_entry: got state %0d start %b want 1 1", cstate, bus.start_findBest); end
        n_cmp++; if (bus.mux_select !== 2'd1 || bus.mem_address !== 16'h68C) begin n_bad++; $display("FAIL find_mux: got sel %0d addr %h want 1 068c", bus.mux_select, bus.mem_address); end
        repeat (3) @(negedge clock);
        bus.done_findBest = 1'b1;
        @(negedge clock);
        bus.done_findBest = 1'b0;
        n_cmp++; if (cstate !== 3'd2 || bus.start_findBest !== 1'b0 || bus.policy_nreset !== 1'b0) begin n_bad++; $display("FAIL clr_entry: got state %0d start %b pnr %b want 2 0 0", cstate, bus.start_findBest, bus.policy_nreset); end
        n_cmp++; if (bus.mem_address !== 16'h0) begin n_bad++; $display("FAIL clr_mem_address: got %h want 0000", bus.mem_address); end
        @(negedge clock);
        n_cmp++; if (cstate !== 3'd3 || bus.start_winnerPolicy !== 1'b1 || bus.policy_nreset !== 1'b1) begin n_bad++; $display("FAIL policy_entry: got state %0d start %b pnr %b want 3 1 1", cstate, bus.start_winnerPolicy, bus.policy_nreset); end
        n_cmp++; if (bus.mux_select !== 2'd2 || bus.mem_address !== 16'h66A) begin n_bad++; $display("FAIL policy_mux: got sel %0d addr %h want 2 066a", bus.mux_select, bus.mem_address); end
        repeat (5) @(negedge clock);
        bus.nexthop_policy = 16'd7;
        bus.done_winnerPolicy = 1'b1;
        @(negedge clock);
        n_cmp++; if (cstate !== 3'd4 || route_nexthop !== 16'd7 || bus.epsilon !== 16'd8) begin n_bad++; $display("FAIL decay_state: got state %0d nh %0d eps %0d want 4 7 8", cstate, route_nexthop, bus.epsilon); end
        n_cmp++; if (bus.start_winnerPolicy !== 1'b0 || route_done !== 1'b0) begin n_bad++; $display("FAIL decay_outputs: got start %b done %b want 0 0", bus.start_winnerPolicy, route_done); end
        @(negedge clock);
        n_cmp++; if (cstate !== 3'd5 || route_done !== 1'b1 || route_error !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got state %0d done %b err %b want 5 1 0", cstate, route_done, route_error); end
        n_cmp++; if (bus.epsilon !== 16'd7) begin n_bad++; $display("FAIL epsilon_decay: got %0d want 7", bus.epsilon); end
        @(negedge clock);
        n_cmp++; if (cstate !== 3'd0 || route_done !== 1'b0 || bus.mem_address !== 16'h0) begin n_bad++; $display("FAIL back_to_idle: got state %0d done %b addr %h want 0 0 0000", cstate, route_done, bus.mem_address); end
        n_cmp++; if (done_pulses - p0 !== 1) begin n_bad++; $display("FAIL done_count: got %0d want 1", done_pulses - p0); end
    endtask

    task automatic test_stale_done();
        int stay;
        start_route = 1'b1;
        @(negedge clock);
        start_route = 1'b0;
        @(negedge clock);
        bus.done_findBest = 1'b1;
        @(negedge clock);
        bus.done_findBest = 1'b0;
        n_cmp++; if (cstate !== 3'd2 || bus.policy_nreset !== 1'b0) begin n_bad++; $display("FAIL stale_clr: got state %0d pnr %b want 2 0", cstate, bus.policy_nreset); end
        bus.done_winnerPolicy = 1'b0;
        @(negedge clock);
        n_cmp++; if (cstate !== 3'd3 || bus.policy_nreset !== 1'b1) begin n_bad++; $display("FAIL stale_clr_one_cycle: got state %0d pnr %b want 3 1", cstate, bus.policy_nreset); end
        stay = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (cstate === 3'd3 && route_done === 1'b0) stay++;
        end
        n_cmp++; if (stay !== 8) begin n_bad++; $display("FAIL stale_hold_policy: got %0d cycles want 8", stay); end
        bus.nexthop_policy = 16'd9;
        bus.done_winnerPolicy = 1'b1;
        repeat (2) @(negedge clock);
        n_cmp++; if (route_done !== 1'b1 || route_nexthop !== 16'd9 || bus.epsilon !== 16'd6) begin n_bad++; $display("FAIL stale_fresh_done: got done %b nh %0d eps %0d want 1 9 6", route_done, route_nexthop, bus.epsilon); end
        @(negedge clock);
    endtask

    task automatic test_decay_saturation();
        bit ok;
        epsilon_load_value = 16'd1;
        epsilon_load = 1'b1;
        @(negedge clock);
        epsilon_load = 1'b0;
        n_cmp++; if (bus.epsilon !== 16'd1) begin n_bad++; $display("FAIL epsilon_load: got %0d want 1", bus.epsilon); end
        epsilon_step = 16'd3;
        run_decision(2, 3, 16'd4, ok);
        n_cmp++; if (!ok || route_nexthop !== 16'd4) begin n_bad++; $display("FAIL sat_run1: got ok %b nh %0d want 1 4", ok, route_nexthop); end
        n_cmp++; if (bus.epsilon !== 16'd0) begin n_bad++; $display("FAIL sat_epsilon1: got %0d want 0", bus.epsilon); end
        run_decision(1, 1, 16'd5, ok);
        n_cmp++; if (!ok || bus.epsilon !== 16'd0) begin n_bad++; $display("FAIL sat_epsilon2: got ok %b eps %0d want 1 0", ok, bus.epsilon); end
    endtask

    task automatic test_timeout_boundary();
        bit ok;
        epsilon_step = 16'd0;
        start_route = 1'b1;
        @(negedge clock);
        start_route = 1'b0;
        repeat (254) @(negedge clock);
        n_cmp++; if (cstate !== 3'd1) begin n_bad++; $display("FAIL find_cycle255_state: got %0d want 1", cstate); end
        bus.done_findBest = 1'b1;
        @(negedge clock);
        bus.done_findBest = 1'b0;
        n_cmp++; if (cstate !== 3'd2 || route_error !== 1'b0) begin n_bad++; $display("FAIL done_wins_timeout: got state %0d err %b want 2 0", cstate, route_error); end
        finish_policy(2, 16'd11, ok);
        n_cmp++; if (!ok || route_nexthop !== 16'd11) begin n_bad++; $display("FAIL boundary_finish: got ok %b nh %0d want 1 11", ok, route_nexthop); end
    endtask

    task automatic test_policy_timeout();
        int n;
        epsilon_load_value = 16'd9;
        epsilon_load = 1'b1;
        @(negedge clock);
        epsilon_load = 1'b0;
        start_route = 1'b1;
        @(negedge clock);
        start_route = 1'b0;
        bus.done_findBest = 1'b1;
        @(negedge clock);
        bus.done_findBest = 1'b0;
        bus.done_winnerPolicy = 1'b0;
        @(negedge clock);
        n = 0;
        while (cstate === 3'd3 && n < 400) begin
            n++;
            @(negedge clock);
        end
        n_cmp++; if (n !== 255) begin n_bad++; $display("FAIL policy_timeout_cycles: got %0d want 255", n); end
        n_cmp++; if (cstate !== 3'd6 || route_done !== 1'b1 || route_error !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got state %0d done %b err %b want 6 1 1", cstate, route_done, route_error); end
        n_cmp++; if (route_nexthop !== 16'd100 || bus.epsilon !== 16'd9) begin n_bad++; $display("FAIL err_values: got nh %0d eps %0d want 100 9", route_nexthop, bus.epsilon); end
        n_cmp++; if (bus.start_winnerPolicy !== 1'b0 || bus.start_findBest !== 1'b0 || bus.mux_select !== 2'd0) begin n_bad++; $display("FAIL err_starts: got %b%b sel %0d want 00 0", bus.start_findBest, bus.start_winnerPolicy, bus.mux_select); end
        @(negedge clock);
        n_cmp++; if (cstate !== 3'd0 || route_done !== 1'b0 || route_error !== 1'b0) begin n_bad++; $display("FAIL err_to_idle: got state %0d done %b err %b want 0 0 0", cstate, route_done, route_error); end
    endtask

    task automatic test_load_priority_and_reset();
        bit ok;
        int p0;
        run_decision(1, 1, 16'd13, ok);
        n_cmp++; if (!ok || route_nexthop !== 16'd13) begin n_bad++; $display("FAIL pre_reset_run: got ok %b nh %0d want 1 13", ok, route_nexthop); end
        epsilon_load_value = 16'd12;
        epsilon_load = 1'b1;
        start_route = 1'b1;
        @(negedge clock);
        start_route = 1'b0;
        epsilon_load = 1'b0;
        n_cmp++; if (cstate !== 3'd1 || bus.epsilon !== 16'd9) begin n_bad++; $display("FAIL start_beats_load: got state %0d eps %0d want 1 9", cstate, bus.epsilon); end
        bus.done_findBest = 1'b1;
        @(negedge clock);
        bus.done_findBest = 1'b0;
        bus.done_winnerPolicy = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (cstate !== 3'd3) begin n_bad++; $display("FAIL pre_reset_policy: got %0d want 3", cstate); end
        p0 = done_pulses;
        nreset = 1'b0;
        @(negedge clock);
        n_cmp++; if (cstate !== 3'd0 || route_done !== 1'b0 || route_error !== 1'b0) begin n_bad++; $display("FAIL midreset_state: got state %0d done %b err %b want 0 0 0", cstate, route_done, route_error); end
        n_cmp++; if (bus.start_winnerPolicy !== 1'b0 || bus.mux_select !== 2'd0 || bus.policy_nreset !== 1'b0) begin n_bad++; $display("FAIL midreset_outputs: got start %b sel %0d pnr %b want 0 0 0", bus.start_winnerPolicy, bus.mux_select, bus.policy_nreset); end
        n_cmp++; if (route_nexthop !== 16'd100 || bus.epsilon !== 16'd8 || bus.mem_address !== 16'h0) begin n_bad++; $display("FAIL midreset_values: got nh %0d eps %0d addr %h want 100 8 0000", route_nexthop, bus.epsilon, bus.mem_address); end
        nreset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (done_pulses !== p0 || cstate !== 3'd0) begin n_bad++; $display("FAIL midreset_no_done: got pulses %0d state %0d want %0d 0", done_pulses, cstate, p0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_decision();
        test_stale_done();
        test_decay_saturation();
        test_timeout_boundary();
        test_policy_timeout();
        test_load_priority_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/route_decision_sequencer.md
# route_decision_sequencer

Controller sequencing one routing decision per request in the Q-routing node. It runs the best-neighbour search, then clears and starts the epsilon-greedy winner-policy block. It owns the shared table-memory address port and the epsilon register, with its decay. It returns the chosen next hop to the packet path and flags sub-block timeouts.

## Interface
- WORD_WIDTH, 16, data/address width
- EPSILON_INIT, 16'd8, epsilon after reset; compared against the 4-bit RNG, so the range is 0..16
- TIMEOUT, 255, maximum wait cycles per sub-block handshake
- NEXTHOP_NONE, 16'd100, "no next hop" encoding (stands for -1)

- clock  in  1  system clock
- nreset  in  1  synchronous, active-low reset
- start_route  in  1  request pulse; sampled in IDLE only
- route_done  out  1  one-cycle pulse; route_nexthop is valid in the same cycle
- route_nexthop  out  WORD_WIDTH  chosen next hop
- route_error  out  1  one-cycle pulse with route_done on timeout
- start_findBest  out  1  level; held high until done_findBest
- done_findBest  in  1  search complete
- address_findBest  in  WORD_WIDTH  search block memory address
- policy_nreset  out  1  active-low reset to the winner-policy block
- start_winnerPolicy  out  1  level; held high until done_winnerPolicy
- done_winnerPolicy  in  1  policy complete; stays high until the policy block is reset
- nexthop_policy  in  WORD_WIDTH  policy result
- address_winnerPolicy  in  WORD_WIDTH  policy block memory address
- mem_address  out  WORD_WIDTH  shared memory address
- mux_select  out  2  0 = none, 1 = findBest, 2 = winnerPolicy
- epsilon  out  WORD_WIDTH  current epsilon, fed to the policy block
- epsilon_step  in  WORD_WIDTH  decay per decision
- epsilon_load  in  1  load epsilon_load_value; accepted only in IDLE
- epsilon_load_value  in  WORD_WIDTH  value for epsilon_load
- cstate  out  3  state, for debug

## Operation
- Reset values:
  - route_done, route_error, start_findBest, start_winnerPolicy, mux_select = 0
  - route_nexthop = NEXTHOP_NONE; epsilon = EPSILON_INIT; policy_nreset = 0; state = IDLE
- States:
  - IDLE(0): policy_nreset = 1.
    - start_route -> FIND. start_route has priority over epsilon_load in the same cycle; the load is dropped.
    - epsilon_load without start_route -> epsilon = epsilon_load_value.
  - FIND(1): start_findBest = 1, mux_select = 1.
    - done_findBest -> CLR; start_findBest drops in the same edge.
  - CLR(2): policy_nreset = 0 for exactly one cycle, then -> POLICY. This clears any stale done_winnerPolicy.
  - POLICY(3): start_winnerPolicy = 1, mux_select = 2.
    - done_winnerPolicy -> DECAY; latch nexthop_policy into route_nexthop.
  - DECAY(4): epsilon = 0 if epsilon < epsilon_step, else epsilon - epsilon_step. Saturating; it never wraps. -> DONE.
  - DONE(5): route_done = 1 for one cycle. -> IDLE.
  - ERR(6): route_done = 1, route_error = 1, route_nexthop = NEXTHOP_NONE, all starts = 0, epsilon unchanged. -> IDLE.
- Timeout:
  - A counter clears on entry to FIND or POLICY and increments each cycle in those states.
  - Reaching TIMEOUT without the corresponding done -> ERR.
  - A done that arrives in the same cycle the count hits TIMEOUT wins.
- mem_address is combinational: address_findBest when mux_select = 1, address_winnerPolicy when 2, else 0.
- nreset low mid-operation: all outputs return to reset values on the next edge; no route_done is produced.

## Timing
- All outputs except mem_address are registered.
- start_route at edge N: start_findBest is high after edge N+1.
- done_findBest at edge F: policy_nreset is low for the cycle after edge F+1; start_winnerPolicy is high after edge F+2.
- done_winnerPolicy at edge P: epsilon is updated at edge P+2; route_done is high for the cycle after edge P+2.
- Total latency: findBest cycles + policy cycles + 5.
- At most one decision is in flight. start_route outside IDLE is ignored, not queued.

## Structure
- Shared package (routing_pkg): WORD_WIDTH, NEXTHOP_NONE, the state encoding, the mux_select encoding (SEL_NONE, SEL_FIND, SEL_POLICY), and the memory map constants 0x668 / 0x68C.
- One sub-module: handshake_timeout (counter, clear, enable, expired flag), instantiated once and reused across FIND and POLICY.

## Test plan
- Normal decision: done_findBest 4 cycles after start, done_winnerPolicy with nexthop_policy = 7 after 6 cycles -> route_nexthop = 7, route_done once, epsilon 8 -> 7 with step 1.
- Decay saturation: epsilon = 1, epsilon_step = 3 -> epsilon = 0 after the decision; a second decision keeps it at 0.
- Policy timeout: done_winnerPolicy never asserted, TIMEOUT = 255 -> at cycle 255 in POLICY, route_error and route_done pulse together, route_nexthop = 100, epsilon unchanged.
- Stale done: done_winnerPolicy held high from the previous run -> CLR pulses policy_nreset low one cycle; the sequencer does not leave POLICY until a fresh done.
- Address mux: address_findBest = 0x68C, address_winnerPolicy = 0x66A -> mem_address follows mux_select in each phase, and is 0 in IDLE.
- Simultaneous start_route and epsilon_load = 12 -> decision starts, epsilon not loaded; nreset low mid-POLICY -> all outputs at reset values the next cycle, no route_done.
